// File: rtl/game_state_ctrl.sv
// Game-flow sequencer: title, intro, fade-in, map, encounter flash, battle, game over.
// The status code drives the map scroller, ROM address stages and the color mapper.
module game_state_ctrl #(
   parameter logic [9:0] INTRO_FRAMES    = 10'd300,
   parameter logic [9:0] FLASH_FRAMES    = 10'd30,
   parameter logic [9:0] ENCOUNTER_STEPS = 10'd240,
   parameter logic [7:0] KEY_CONFIRM     = 8'h28,
   parameter logic [7:0] KEY_LEFT        = 8'h04,
   parameter logic [7:0] KEY_RIGHT       = 8'h07
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic       battle_done,
   input  logic       player_dead,
   output logic [3:0] status,
   output logic [3:0] fade_level,
   output logic       encounter_pulse,
   output logic [9:0] walk_count
);

   typedef enum logic [3:0] {
      TITLE     = 4'd0,
      INTRO     = 4'd1,
      FADE_IN   = 4'd2,
      MAP1      = 4'd3,
      ENCOUNTER = 4'd4,
      BATTLE    = 4'd5,
      GAMEOVER  = 4'd6
   } state_t;

   state_t     state, state_n;
   logic [9:0] timer, timer_n, timer_inc, walk_n, walk_inc;
   logic [3:0] fade_n;
   logic       pulse_n;
   logic       frame_clk_d, frame_tick;
   logic [7:0] key_prev;
   logic       confirm_press, walking;

   // Edge detect against last Clk's keycode so a held Enter fires once.
   assign confirm_press = (keycode == KEY_CONFIRM) && (key_prev != KEY_CONFIRM);
   assign walking       = (keycode == KEY_LEFT) || (keycode == KEY_RIGHT);
   assign timer_inc     = timer + 10'd1;
   assign walk_inc      = (walk_count == 10'h3FF) ? walk_count : walk_count + 10'd1;
   assign status        = state;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state           <= TITLE;
         timer           <= '0;
         fade_level      <= '0;
         walk_count      <= '0;
         encounter_pulse <= 1'b0;
         frame_clk_d     <= 1'b0;
         frame_tick      <= 1'b0;
         key_prev        <= '0;
      end else begin
         state           <= state_n;
         timer           <= timer_n;
         fade_level      <= fade_n;
         walk_count      <= walk_n;
         encounter_pulse <= pulse_n;
         frame_clk_d     <= frame_clk;
         frame_tick      <= frame_clk & ~frame_clk_d;
         key_prev        <= keycode;
      end
   end

   always_comb begin
      state_n = state;
      timer_n = timer;
      fade_n  = fade_level;
      walk_n  = walk_count;
      pulse_n = 1'b0;
      case (state)
         TITLE: begin
            timer_n = '0;
            fade_n  = '0;
            if (confirm_press) state_n = INTRO;
         end
         INTRO: begin
            // A skip and a tick in the same Clk leave exactly once; the timer does not advance.
            if (confirm_press || (frame_tick && timer == INTRO_FRAMES - 10'd1)) begin
               state_n = FADE_IN;
               timer_n = '0;
               fade_n  = 4'd15;
            end else if (frame_tick) begin
               timer_n = timer_inc;
            end
         end
         FADE_IN: begin
            if (frame_tick) begin
               if (fade_level == 4'd0) state_n = MAP1;
               else                    fade_n  = fade_level - 4'd1;
            end
         end
         MAP1: begin
            fade_n = '0;
            if (frame_tick && walking) begin
               walk_n = walk_inc;
               if (walk_inc == ENCOUNTER_STEPS) begin
                  state_n = ENCOUNTER;
                  pulse_n = 1'b1;
                  timer_n = '0;
               end
            end
         end
         ENCOUNTER: begin
            if (frame_tick) begin
               if (timer == FLASH_FRAMES - 10'd1) begin
                  state_n = BATTLE;
                  timer_n = '0;
                  fade_n  = '0;
                  walk_n  = '0;
               end else begin
                  timer_n = timer_inc;
                  fade_n  = timer_inc[2] ? 4'd15 : 4'd0;
               end
            end
         end
         BATTLE: begin
            if (player_dead) begin
               state_n = GAMEOVER;
               fade_n  = 4'd15;
            end else if (battle_done) begin
               state_n = FADE_IN;
               fade_n  = 4'd15;
            end
         end
         GAMEOVER: begin
            fade_n = 4'd15;
            if (confirm_press) begin
               state_n = TITLE;
               fade_n  = '0;
            end
         end
         default: begin
            state_n = TITLE;
            timer_n = '0;
            fade_n  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed walk through the game flow plus a random soak, checked every Clk against
// a tick-counting reference model of the game rules.
module tb_game_state_ctrl;

   localparam int IF = 5;
   localparam int FF = 8;
   localparam int ES = 3;

   logic       Clk = 1'b0;
   logic       Reset, frame_clk, battle_done, player_dead;
   logic [7:0] keycode;
   logic [3:0] status, fade_level;
   logic       encounter_pulse;
   logic [9:0] walk_count;

   int vectors = 0, miscompares = 0, pulses = 0;

   int         m_state, m_timer, m_fade, m_walk;
   bit         m_pulse, m_tick, m_fclk_d;
   logic [7:0] m_kprev;

   logic [7:0] keys [6] = '{8'h00, 8'h28, 8'h04, 8'h07, 8'h16, 8'h28};

   game_state_ctrl #(
      .INTRO_FRAMES(10'd5), .FLASH_FRAMES(10'd8), .ENCOUNTER_STEPS(10'd3),
      .KEY_CONFIRM(8'h28), .KEY_LEFT(8'h04), .KEY_RIGHT(8'h07)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
      .battle_done(battle_done), .player_dead(player_dead), .status(status),
      .fade_level(fade_level), .encounter_pulse(encounter_pulse), .walk_count(walk_count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_timer = 0; m_fade = 0; m_walk = 0;
      m_pulse = 1'b0; m_tick = 1'b0; m_fclk_d = 1'b0; m_kprev = 8'h00;
   endtask

   // One Clk of the game rules; the timer counts frame ticks seen in the current state.
   task automatic model_clk(input logic [7:0] kc, input logic fc, input logic bd, input logic pd);
      bit conf, walk, tick;
      int ns, nt, nf, nw;
      bit np;
      conf = (kc == 8'h28) && (m_kprev != 8'h28);
      walk = (kc == 8'h04) || (kc == 8'h07);
      tick = m_tick;
      ns = m_state; nt = m_timer; nf = m_fade; nw = m_walk; np = 1'b0;
      case (m_state)
         0: begin nt = 0; nf = 0; if (conf) ns = 1; end
         1: if (conf || (tick && m_timer + 1 == IF)) begin ns = 2; nt = 0; nf = 15; end
            else if (tick) nt = m_timer + 1;
         2: if (tick) begin if (m_fade == 0) ns = 3; else nf = m_fade - 1; end
         3: begin
            nf = 0;
            if (tick && walk) begin
               nw = (m_walk < 1023) ? m_walk + 1 : 1023;
               if (nw == ES) begin ns = 4; np = 1'b1; nt = 0; end
            end
         end
         4: if (tick) begin
            if (m_timer + 1 == FF) begin ns = 5; nt = 0; nf = 0; nw = 0; end
            else begin nt = m_timer + 1; nf = ((nt / 4) % 2 == 1) ? 15 : 0; end
         end
         5: if (pd) begin ns = 6; nf = 15; end
            else if (bd) begin ns = 2; nf = 15; end
         6: begin nf = 15; if (conf) begin ns = 0; nf = 0; end end
         default: ns = 0;
      endcase
      m_state = ns; m_timer = nt; m_fade = nf; m_walk = nw; m_pulse = np;
      m_tick = fc && !m_fclk_d;
      m_fclk_d = fc;
      m_kprev = kc;
   endtask

   task automatic step();
      logic [7:0]  kc;
      logic        fc, bd, pd;
      logic [31:0] obs, exp;
      kc = keycode; fc = frame_clk; bd = battle_done; pd = player_dead;
      @(posedge Clk);
      model_clk(kc, fc, bd, pd);
      #1;
      if (encounter_pulse === 1'b1) pulses++;
      obs = {13'd0, status, fade_level, encounter_pulse, walk_count};
      exp = {13'd0, m_state[3:0], m_fade[3:0], m_pulse, m_walk[9:0]};
      check("cycle", obs, exp);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_clk = 1'b1;
         repeat (1 + $urandom_range(2)) step();
         frame_clk = 1'b0;
         repeat (2 + $urandom_range(2)) step();
      end
   endtask

   initial begin
      Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00; battle_done = 1'b0; player_dead = 1'b0;
      model_reset();
      #1;
      check("reset_status", 32'(status), 0);
      check("reset_fade", 32'(fade_level), 0);
      check("reset_pulse", 32'(encounter_pulse), 0);
      check("reset_walk", 32'(walk_count), 0);
      @(negedge Clk);
      Reset = 1'b0;
      repeat (3) step();

      // Held Enter advances once; release and re-press skips the intro.
      keycode = 8'h28;
      repeat (100) step();
      check("held_enter", 32'(status), 1);
      keycode = 8'h00;
      repeat (3) step();
      keycode = 8'h28;
      step();
      check("skip_status", 32'(status), 2);
      check("skip_fade", 32'(fade_level), 15);
      keycode = 8'h00;
      step();
      for (int k = 0; k < 15; k++) begin
         frames(1);
         check("fade_ramp", 32'(fade_level), 32'(14 - k));
      end
      check("fade_hold", 32'(status), 2);
      frames(1);
      check("map_entry", 32'(status), 3);

      // Walking, non-walking hold, then the encounter step.
      keycode = 8'h07;
      frames(2);
      check("walk_two", 32'(walk_count), 2);
      keycode = 8'h16;
      frames(5);
      check("walk_hold", 32'(walk_count), 2);
      pulses = 0;
      keycode = 8'h04;
      frames(1);
      check("walk_three", 32'(walk_count), 3);
      check("encounter", 32'(status), 4);
      check("pulse_count", 32'(pulses), 1);

      // Encounter flash pattern.
      keycode = 8'h00;
      for (int k = 1; k < 8; k++) begin
         frames(1);
         check("flash_fade", 32'(fade_level), (k >= 4) ? 15 : 0);
      end
      frames(1);
      check("battle_entry", 32'(status), 5);
      check("battle_walk", 32'(walk_count), 0);

      // Simultaneous strobes: death wins; confirm returns to title.
      battle_done = 1'b1; player_dead = 1'b1;
      step();
      battle_done = 1'b0; player_dead = 1'b0;
      step();
      check("gameover", 32'(status), 6);
      check("gameover_fade", 32'(fade_level), 15);
      keycode = 8'h28;
      step();
      check("title_again", 32'(status), 0);

      // Intro auto-advance one Clk after the fifth tick.
      keycode = 8'h00;
      step();
      keycode = 8'h28;
      step();
      keycode = 8'h00;
      step();
      frames(4);
      check("intro_wait", 32'(status), 1);
      frame_clk = 1'b1;
      step();
      check("intro_pre", 32'(status), 1);
      step();
      check("intro_adv", 32'(status), 2);
      frame_clk = 1'b0;
      repeat (2) step();

      // Back through the map to battle, then win it.
      frames(16);
      keycode = 8'h07;
      frames(3);
      keycode = 8'h00;
      frames(8);
      check("battle2", 32'(status), 5);
      battle_done = 1'b1;
      step();
      battle_done = 1'b0;
      step();
      check("won_status", 32'(status), 2);
      check("won_fade", 32'(fade_level), 15);

      // Asynchronous reset from BATTLE, observed before the next edge.
      frames(16);
      keycode = 8'h04;
      frames(3);
      keycode = 8'h00;
      frames(8);
      check("battle3", 32'(status), 5);
      check("battle3_walk", 32'(walk_count), 0);
      #2 Reset = 1'b1;
      #1;
      check("async_status", 32'(status), 0);
      check("async_fade", 32'(fade_level), 0);
      model_reset();
      @(negedge Clk);
      Reset = 1'b0;

      // Random soak.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) keycode = keys[$urandom_range(5)];
         if ($urandom_range(2) == 0) frame_clk = ~frame_clk;
         battle_done = ($urandom_range(15) == 0);
         player_dead = ($urandom_range(31) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Top-level game-flow FSM that produces the 4-bit `status` code consumed by the map scroller, the sprite/map ROM address stages and the color mapper. It sequences title, intro, fade-in, map exploration, encounter flash, battle and game-over. Inputs are the keyboard keycode and battle-outcome strobes; the frame clock paces all timing. It sits directly upstream of the map1 scroller, which only moves while `status` == 3.

Parameters:
INTRO_FRAMES, 10'd300, frame ticks spent in INTRO before auto-advance (1..1023)
FLASH_FRAMES, 10'd30, frame ticks spent in ENCOUNTER flash (1..1023)
ENCOUNTER_STEPS, 10'd240, walking frame ticks in MAP1 before an encounter (1..1023)
KEY_CONFIRM, 8'h28, keycode for confirm (Enter)
KEY_LEFT, 8'h04, walk keycode A
KEY_RIGHT, 8'h07, walk keycode D

Ports:
Clk  input  1  system clock (50 MHz)
Reset  input  1  asynchronous, active-high reset
frame_clk  input  1  vertical-sync-rate frame clock, asynchronous level
keycode  input  8  current USB keycode, 0 = none
battle_done  input  1  one-Clk pulse: battle won/fled
player_dead  input  1  one-Clk pulse: HP reached 0
status  output  4  game state code (see states)
fade_level  output  4  darkness for color mapper, 15 = black, 0 = none
encounter_pulse  output  1  one-Clk pulse on entry to ENCOUNTER
walk_count  output  10  current encounter step counter (debug/HUD)

Behaviour:
- Reset (async, active-high): status=0, fade_level=0, encounter_pulse=0, walk_count=0, all internal counters and history registers 0. Asserting Reset in any state returns to TITLE immediately.
- frame_tick: frame_clk_d <= frame_clk; frame_tick <= frame_clk & ~frame_clk_d. Both are registered, so frame_tick is a one-Clk pulse 1 Clk after the sampled rising edge.
- confirm_press: key_prev <= keycode every Clk. confirm_press = (keycode==KEY_CONFIRM) & (key_prev!=KEY_CONFIRM). A held key presses once only.
- walking = keycode==KEY_LEFT or keycode==KEY_RIGHT.
- States (status code):
  - 0 TITLE: confirm_press -> 1. timer cleared.
  - 1 INTRO: timer += 1 per frame_tick. At the tick where timer reaches INTRO_FRAMES-1 -> 2. Also confirm_press -> 2 (skip). Exit clears timer.
  - 2 FADE_IN: entry loads fade_level=15. Each frame_tick decrements it. A frame_tick with fade_level==0 -> 3, so FADE_IN lasts 16 ticks.
  - 3 MAP1: fade_level=0. On frame_tick && walking, walk_count += 1. When the increment makes walk_count == ENCOUNTER_STEPS -> 4 and encounter_pulse=1 for that Clk. Non-walking keycodes hold walk_count.
  - 4 ENCOUNTER: timer += 1 per frame_tick. fade_level toggles 15/0 every 4 ticks (timer[2] ? 15 : 0). When timer reaches FLASH_FRAMES-1 on a tick -> 5, clear timer, fade_level=0.
  - 5 BATTLE: walk_count cleared on entry. player_dead -> 6. Else battle_done -> 2 (re-fade into map). If both strobe in the same Clk, player_dead wins.
  - 6 GAMEOVER: fade_level=15. confirm_press -> 0.
  - Codes 7..15 are unreachable. If ever latched, next Clk -> 0.
- Transition timing: all outputs are registered. status changes 1 Clk after the triggering event or tick, and never changes more than once per Clk.
- Events in states that do not use them are ignored: battle_done/player_dead outside 5, confirm_press in 2/3/4/5.
- A frame_tick and a confirm_press in the same Clk in INTRO go to 2 once. The timer does not also advance.
- Counters are 10-bit unsigned. walk_count saturates at 1023 and cannot wrap because ENCOUNTER_STEPS <= 1023.

Test Plan:
1. Reset mid-BATTLE (status=5, walk_count=0) -> status=0, fade_level=0 asynchronously, before the next Clk edge.
2. TITLE, keycode held 8'h28 for 100 Clk -> exactly one transition to 1. Release then re-press -> 2 (skip). Then 16 frame ticks -> fade_level 15,14..0, then status=3.
3. INTRO_FRAMES=5, no keys, status=1 -> status=2 exactly 1 Clk after the 5th frame_tick.
4. ENCOUNTER_STEPS=3, status=3, keycode=8'h07 for 2 ticks, keycode=8'h16 for 5 ticks, 8'h04 for 1 tick -> walk_count 1,2,2..2,3. status=4 with one encounter_pulse on the 3rd walking tick.
5. FLASH_FRAMES=8 in ENCOUNTER -> fade_level 0 for ticks 0-3, 15 for ticks 4-7. status=5 after the 8th tick, walk_count=0.
6. BATTLE with battle_done and player_dead asserted in the same Clk -> status=6. Then confirm_press -> status=0. A separate run with only battle_done -> status=2, fade_level=15.
